// File: rtl/brs_pkg.sv
// Shared pin indices and byte helpers for the BRS XOR unmask receiver.
// Build option: define BRS_KEY_ROTATE_EN to rotate the key after every accepted byte.
package brs_pkg;

    localparam int KEY_LOAD   = 0;
    localparam int DATA_VALID = 1;
    localparam int OUT_READY  = 2;
    localparam int OUT_VALID  = 4;
    localparam int FULL       = 5;
    localparam int ERR        = 6;
    localparam int KEY_OK     = 7;

    localparam logic [7:0] UIO_OE_MASK = 8'hF0;

    // The top bit of C only carries the check bit, so it is never returned as data.
    function automatic logic [7:0] decode_byte(input logic [7:0] c, input logic [7:0] k);
        return {1'b0, c[6:0] ^ k[6:0]};
    endfunction

    function automatic logic [7:0] rotate_key(input logic [7:0] k);
        return {k[6:0], k[7]};
    endfunction

endpackage

// File: rtl/brs_if.sv
// Pin bundle of the BRS unmask tile: the host drives the inputs, the tile drives the outputs.
interface brs_if;

    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    modport master (
        output ena, ui_in, uio_in,
        input  uo_out, uio_out, uio_oe
    );

    modport slave (
        input  ena, ui_in, uio_in,
        output uo_out, uio_out, uio_oe
    );

endinterface

// File: rtl/brs_sync_edge.sv
// Multi-flop synchroniser for one asynchronous control pin, followed by a rising-edge pulse.
module brs_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pin,
    output logic pulse
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   last_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            last_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pin};
            last_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign pulse = sync_q[SYNC_STAGES-1] & ~last_q;

endmodule

// File: rtl/tt_um_brs_xor_unmask.sv
// Receive side of BRS XOR masking: unmasks strobed bytes with a loaded key into a small FIFO.
// Build option: define BRS_KEY_ROTATE_EN to rotate the key left by one after each accepted byte.
module tt_um_brs_xor_unmask
    import brs_pkg::*;
#(
    parameter int FIFO_DEPTH  = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    brs_if.slave pins
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    logic key_pulse;
    logic data_pulse;
    logic ready_pulse;

    logic [7:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;
    logic [7:0]       key;
    logic             key_ok;
    logic             err;
    logic [7:0]       head_q;

    logic             data_take;
    logic             fifo_empty;
    logic             fifo_full;
    logic             do_pop;
    logic             do_push;
    logic             set_err;
    logic [7:0]       decoded;
    logic [PTR_W-1:0] rd_ptr_n;
    logic [CNT_W-1:0] count_n;
    logic [7:0]       head_n;
    logic [7:0]       uio_out_w;
    logic             unused_ok;

    brs_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_key (
        .clk   (clk),
        .rst_n (rst_n),
        .pin   (pins.uio_in[KEY_LOAD]),
        .pulse (key_pulse)
    );

    brs_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_data (
        .clk   (clk),
        .rst_n (rst_n),
        .pin   (pins.uio_in[DATA_VALID]),
        .pulse (data_pulse)
    );

    brs_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_ready (
        .clk   (clk),
        .rst_n (rst_n),
        .pin   (pins.uio_in[OUT_READY]),
        .pulse (ready_pulse)
    );

    // A key load in the same cycle as a data strobe swallows the data strobe.
    // A full FIFO still accepts a byte when a pop frees the head slot in the same cycle.
    always_comb begin
        data_take  = data_pulse & ~key_pulse;
        fifo_empty = (count == '0);
        fifo_full  = (count == CNT_W'(FIFO_DEPTH));
        do_pop     = ready_pulse & ~fifo_empty;
        decoded    = decode_byte(pins.ui_in, key);
        do_push    = data_take & key_ok & (~fifo_full | do_pop);
        set_err    = data_take & (~key_ok | (pins.ui_in[7] != key[7]) | (fifo_full & ~do_pop));
        rd_ptr_n   = do_pop ? rd_ptr + PTR_W'(1) : rd_ptr;
        count_n    = count + CNT_W'(do_push) - CNT_W'(do_pop);
        head_n     = 8'h00;
        if (count_n != '0) begin
            if (do_push && (rd_ptr_n == wr_ptr)) begin
                head_n = decoded;
            end else begin
                head_n = mem[rd_ptr_n];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= 8'h00;
            end
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            key    <= 8'h00;
            key_ok <= 1'b0;
            err    <= 1'b0;
            head_q <= 8'h00;
        end else begin
            if (key_pulse) begin
                key    <= pins.ui_in;
                key_ok <= 1'b1;
                err    <= 1'b0;
            end else begin
                if (set_err) begin
                    err <= 1'b1;
                end
`ifdef BRS_KEY_ROTATE_EN
                if (do_push) begin
                    key <= rotate_key(key);
                end
`endif
            end
            if (do_push) begin
                mem[wr_ptr] <= decoded;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            rd_ptr <= rd_ptr_n;
            count  <= count_n;
            head_q <= head_n;
        end
    end

    always_comb begin
        uio_out_w            = 8'h00;
        uio_out_w[OUT_VALID] = ~fifo_empty;
        uio_out_w[FULL]      = fifo_full;
        uio_out_w[ERR]       = err;
        uio_out_w[KEY_OK]    = key_ok;
    end

    assign pins.uo_out  = head_q;
    assign pins.uio_out = uio_out_w;
    assign pins.uio_oe  = UIO_OE_MASK;

    assign unused_ok = &{1'b0, pins.ena, pins.uio_in[7:3]};

endmodule

// File: tb/tb_tt_um_brs_xor_unmask.sv
// Bench for tt_um_brs_xor_unmask: queue-based reference model checked every cycle, plus directed cases.
module tb_tt_um_brs_xor_unmask;

    localparam int DEPTH = 4;
    localparam int SYNC  = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    always #5 clk = ~clk;

    brs_if pins();

    tt_um_brs_xor_unmask #(.FIFO_DEPTH(DEPTH), .SYNC_STAGES(SYNC)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .pins  (pins)
    );

    int compared   = 0;
    int mismatched = 0;
    bit check_en   = 1'b0;

    logic [7:0] m_q[$];
    logic [7:0] m_key;
    bit         m_key_ok;
    bit         m_err;

    function automatic logic [7:0] exp_uo();
        return (m_q.size() != 0) ? m_q[0] : 8'h00;
    endfunction

    function automatic logic [7:0] exp_uio();
        return {m_key_ok, m_err, (m_q.size() == DEPTH), (m_q.size() != 0), 4'b0000};
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_key    = 8'h00;
        m_key_ok = 1'b0;
        m_err    = 1'b0;
    endtask

    // Model of one action edge given which strobes fired and the byte on ui_in.
    task automatic model_apply(input logic [2:0] mask, input logic [7:0] c);
        bit         pop;
        bit         push;
        logic [7:0] d;
        pop  = mask[2] && (m_q.size() > 0);
        push = 1'b0;
        d    = 8'h00;
        if (mask[0]) begin
            m_key    = c;
            m_key_ok = 1'b1;
            m_err    = 1'b0;
        end else if (mask[1]) begin
            if (!m_key_ok) begin
                m_err = 1'b1;
            end else begin
                d = {1'b0, c[6:0] ^ m_key[6:0]};
                if (c[7] != m_key[7]) m_err = 1'b1;
                if (m_q.size() == DEPTH && !pop) m_err = 1'b1;
                else push = 1'b1;
            end
        end
        if (pop) m_q.delete(0);
        if (push) begin
            m_q.push_back(d);
`ifdef BRS_KEY_ROTATE_EN
            m_key = {m_key[6:0], m_key[7]};
`endif
        end
    endtask

    task automatic check_output(input string name, input logic [7:0] act, input logic [7:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (check_en) begin
            check_output("uo_out", pins.uo_out, exp_uo());
            check_output("uio_out", pins.uio_out, exp_uio());
            check_output("uio_oe", pins.uio_oe, 8'hF0);
        end
    end

    // Raise the requested strobes, update the model on the action edge, then release them.
    task automatic apply_stimulus(input logic [2:0] mask, input logic [7:0] data);
        @(negedge clk);
        pins.ui_in       = data;
        pins.uio_in[2:0] = mask;
        repeat (SYNC + 1) @(posedge clk);
        #1 model_apply(mask, data);
        @(negedge clk);
        pins.uio_in[2:0] = 3'b000;
        repeat (SYNC + 1) @(posedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1;
        rst_n       = 1'b0;
        pins.uio_in = 8'h00;
        model_reset();
        @(negedge clk);
        #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);
    endtask

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    logic [7:0] second_byte;
    logic [7:0] uio_after_t3;

    initial begin
        pins.ena    = 1'b1;
        pins.ui_in  = 8'h00;
        pins.uio_in = 8'h00;
        model_reset();
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b1;
        check_en = 1'b1;

        settle();
        check_output("reset_uo", pins.uo_out, 8'h00);
        check_output("reset_uio", pins.uio_out, 8'h00);

        apply_stimulus(3'b010, 8'h1B);
        settle();
        check_output("t1_uo", pins.uo_out, 8'h00);
        check_output("t1_uio", pins.uio_out, 8'h40);

        apply_stimulus(3'b001, 8'h5A);
        settle();
        check_output("t2_key_uio", pins.uio_out, 8'h80);
        apply_stimulus(3'b010, 8'h1B);
        settle();
        check_output("t2_uo", pins.uo_out, 8'h41);
        check_output("t2_uio", pins.uio_out, 8'h90);

`ifdef BRS_KEY_ROTATE_EN
        second_byte  = 8'h41;
        uio_after_t3 = 8'h80;
`else
        second_byte  = 8'h2F;
        uio_after_t3 = 8'hC0;
`endif
        apply_stimulus(3'b010, 8'hF5);
        apply_stimulus(3'b100, 8'h00);
        settle();
        check_output("t3_second", pins.uo_out, second_byte);
        apply_stimulus(3'b100, 8'h00);
        settle();
        check_output("t3_empty_uo", pins.uo_out, 8'h00);
        check_output("t3_empty_uio", pins.uio_out, uio_after_t3);

        do_reset();
        apply_stimulus(3'b001, 8'h5A);
        apply_stimulus(3'b010, 8'h9B);
        settle();
        check_output("t4_uo", pins.uo_out, 8'h41);
        check_output("t4_uio", pins.uio_out, 8'hD0);
        apply_stimulus(3'b001, 8'h5A);
        settle();
        check_output("t4_clear_uio", pins.uio_out, 8'h90);

        do_reset();
        apply_stimulus(3'b001, 8'h00);
        for (int i = 1; i <= 4; i++) apply_stimulus(3'b010, 8'(i));
        settle();
        check_output("t5_full_uio", pins.uio_out, 8'hB0);
        apply_stimulus(3'b010, 8'h05);
        settle();
        check_output("t5_drop_uio", pins.uio_out, 8'hF0);
        for (int i = 1; i <= 4; i++) begin
            settle();
            check_output("t5_pop", pins.uo_out, 8'(i));
            apply_stimulus(3'b100, 8'h00);
        end
        settle();
        check_output("t5_empty_uo", pins.uo_out, 8'h00);
        check_output("t5_empty_uio", pins.uio_out, 8'hC0);

        do_reset();
        apply_stimulus(3'b001, 8'h00);
        for (int i = 1; i <= 4; i++) apply_stimulus(3'b010, 8'(i));
        apply_stimulus(3'b110, 8'h06);
        settle();
        check_output("t7_pushpop_uo", pins.uo_out, 8'h02);
        check_output("t7_pushpop_uio", pins.uio_out, 8'hB0);
        apply_stimulus(3'b011, 8'h77);
        settle();
        check_output("t7_keywins_uo", pins.uo_out, 8'h02);
        check_output("t7_keywins_uio", pins.uio_out, 8'hB0);

        do_reset();
        apply_stimulus(3'b001, 8'h33);
        apply_stimulus(3'b010, 8'h10);
        apply_stimulus(3'b010, 8'h20);
        @(negedge clk);
        pins.ui_in  = 8'h44;
        pins.uio_in = 8'h02;
        @(negedge clk);
        #1;
        rst_n       = 1'b0;
        pins.uio_in = 8'h00;
        model_reset();
        settle();
        check_output("t6_rst_uo", pins.uo_out, 8'h00);
        check_output("t6_rst_uio", pins.uio_out, 8'h00);
        rst_n = 1'b1;
        repeat (SYNC + 2) @(posedge clk);
        apply_stimulus(3'b010, 8'h55);
        settle();
        check_output("t6_after_uo", pins.uo_out, 8'h00);
        check_output("t6_after_uio", pins.uio_out, 8'h40);

        do_reset();
        for (int n = 0; n < 300; n++) begin
            logic [2:0] mask;
            mask[0] = ($urandom_range(0, 9) == 0);
            mask[1] = ($urandom_range(0, 2) != 0);
            mask[2] = ($urandom_range(0, 2) == 0);
            apply_stimulus(mask, 8'($urandom));
        end

        settle();
        check_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
